// File: rtl/branch_pkg.sv
// Shared definitions for the conditional-branch sequencer: instruction field
// positions, the default branch opcode and the control-step state encoding.
package branch_pkg;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int C2_MSB = 20;
    localparam int C2_LSB = 19;
    localparam int C_MSB  = 18;
    localparam int C_LSB  = 0;

    localparam logic [OP_MSB-OP_LSB:0] BR_OPCODE_DEFAULT = 5'b10010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CON,
        S_PCY,
        S_ADD,
        S_PCLD,
        S_DONE
    } state_t;

    // One control step's worth of bus/register strobes (pc_in excluded: it also needs con_q).
    typedef struct packed {
        logic gra_rout;
        logic pc_out;
        logic y_in;
        logic c_out;
        logic add_op;
        logic z_in;
        logic zlo_out;
    } strobes_t;

endpackage

// File: rtl/branch_field_decode.sv
// Combinational field extraction from the latched branch instruction:
// condition code, Ra select and the sign-extended C offset.
module branch_field_decode
    import branch_pkg::*;
(
    input  logic [31:0] ir_q,
    output logic [1:0]  c2,
    output logic [3:0]  ra_sel,
    output logic [31:0] c_sext
);

    assign c2     = ir_q[C2_MSB:C2_LSB];
    assign ra_sel = ir_q[RA_MSB:RA_LSB];
    assign c_sext = {{(31 - C_MSB){ir_q[C_MSB]}}, ir_q[C_MSB:C_LSB]};

    // Opcode and bits 22:21 are not needed once the instruction is in the sequencer.
    logic unused_bits;
    assign unused_bits = ^{ir_q[OP_MSB:OP_LSB], ir_q[22:21]};

endmodule

// File: rtl/branch_sequencer.sv
// Control-step sequencer for conditional branches: latches CON, drives the
// PC + sext(C) datapath strobes, loads PC only when taken, counts taken branches.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter logic [4:0] BR_OPCODE      = BR_OPCODE_DEFAULT,
    parameter bit         SKIP_NOT_TAKEN = 1'b1,
    parameter int         CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [31:0]      ir,
    input  logic             con_d,
    output logic [1:0]       c2,
    output logic [3:0]       ra_sel,
    output logic             gra_rout,
    output logic             pc_out,
    output logic             y_in,
    output logic             c_out,
    output logic             add_op,
    output logic             z_in,
    output logic             zlo_out,
    output logic             pc_in,
    output logic [31:0]      c_sext,
    output logic             con_q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] taken_count
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] ir_q;
    strobes_t    strb;
    logic        accept;

    assign accept = (state_q == S_IDLE) && start && (ir[OP_MSB:OP_LSB] == BR_OPCODE);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, exactly like the hardware.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            con_q       <= 1'b0;
            taken_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ir_q <= ir;
            end
            if (state_q == S_CON) begin
                con_q <= con_d;
            end
            if (state_q == S_PCLD && con_q) begin
                taken_count <= taken_count + CNT_W'(1);
            end
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        strb    = '0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_d = S_CON;
                end
            end
            S_CON: begin
                strb.gra_rout = 1'b1;
                // con_d is live this cycle; con_q only holds it from the next edge.
                state_d = (SKIP_NOT_TAKEN && !con_d) ? S_DONE : S_PCY;
            end
            S_PCY: begin
                strb.pc_out = 1'b1;
                strb.y_in   = 1'b1;
                state_d     = S_ADD;
            end
            S_ADD: begin
                strb.c_out  = 1'b1;
                strb.add_op = 1'b1;
                strb.z_in   = 1'b1;
                state_d     = S_PCLD;
            end
            S_PCLD: begin
                strb.zlo_out = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign gra_rout = strb.gra_rout;
    assign pc_out   = strb.pc_out;
    assign y_in     = strb.y_in;
    assign c_out    = strb.c_out;
    assign add_op   = strb.add_op;
    assign z_in     = strb.z_in;
    assign zlo_out  = strb.zlo_out;
    assign pc_in    = (state_q == S_PCLD) && con_q;

    branch_field_decode u_decode (
        .ir_q   (ir_q),
        .c2     (c2),
        .ra_sel (ra_sel),
        .c_sext (c_sext)
    );

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench: three sequencer variants (skip, no-skip, 4-bit counter)
// driven in lockstep and compared against a latency-timeline reference model.
module tb_branch_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] ir;
    logic        con_d;

    logic [1:0]  c2_v     [3];
    logic [3:0]  ra_v     [3];
    logic [31:0] csext_v  [3];
    logic        gra_v    [3];
    logic        pco_v    [3];
    logic        yin_v    [3];
    logic        cout_v   [3];
    logic        add_v    [3];
    logic        zin_v    [3];
    logic        zlo_v    [3];
    logic        pcin_v   [3];
    logic        conq_v   [3];
    logic        busy_v   [3];
    logic        done_v   [3];
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
    logic [3:0]  cnt_c;

    logic [9:0]  obs [3];
    int unsigned cnt_m [3];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    branch_sequencer dut_a (
        .clock(clock), .reset_n(reset_n), .start(start), .ir(ir), .con_d(con_d),
        .c2(c2_v[0]), .ra_sel(ra_v[0]), .gra_rout(gra_v[0]), .pc_out(pco_v[0]),
        .y_in(yin_v[0]), .c_out(cout_v[0]), .add_op(add_v[0]), .z_in(zin_v[0]),
        .zlo_out(zlo_v[0]), .pc_in(pcin_v[0]), .c_sext(csext_v[0]), .con_q(conq_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .taken_count(cnt_a)
    );

    branch_sequencer #(.SKIP_NOT_TAKEN(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start), .ir(ir), .con_d(con_d),
        .c2(c2_v[1]), .ra_sel(ra_v[1]), .gra_rout(gra_v[1]), .pc_out(pco_v[1]),
        .y_in(yin_v[1]), .c_out(cout_v[1]), .add_op(add_v[1]), .z_in(zin_v[1]),
        .zlo_out(zlo_v[1]), .pc_in(pcin_v[1]), .c_sext(csext_v[1]), .con_q(conq_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .taken_count(cnt_b)
    );

    branch_sequencer #(.CNT_W(4)) dut_c (
        .clock(clock), .reset_n(reset_n), .start(start), .ir(ir), .con_d(con_d),
        .c2(c2_v[2]), .ra_sel(ra_v[2]), .gra_rout(gra_v[2]), .pc_out(pco_v[2]),
        .y_in(yin_v[2]), .c_out(cout_v[2]), .add_op(add_v[2]), .z_in(zin_v[2]),
        .zlo_out(zlo_v[2]), .pc_in(pcin_v[2]), .c_sext(csext_v[2]), .con_q(conq_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .taken_count(cnt_c)
    );

    // Bit order: gra pc_out y_in c_out add z_in zlo pc_in busy done
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            obs[i] = {gra_v[i], pco_v[i], yin_v[i], cout_v[i], add_v[i], zin_v[i],
                      zlo_v[i], pcin_v[i], busy_v[i], done_v[i]};
        end
    end

    typedef struct {
        logic [31:0] ir;
        bit          con;
        int          extra_off;
        logic [1:0]  c2;
        logic [3:0]  ra;
        logic [31:0] c_sext;
    } vec_t;

    function automatic bit skip_of(int i);
        return i != 1;
    endfunction

    // Expected strobes k cycles after the start cycle, from the latency rules.
    function automatic logic [9:0] exp_vec(int k, bit skip, bit con);
        int len;
        len = (skip && !con) ? 2 : 5;
        if (k < 1 || k > len) return 10'b0;
        if (k == len)         return 10'b0000000011;
        case (k)
            1:       return 10'b1000000010;
            2:       return 10'b0110000010;
            3:       return 10'b0001110010;
            default: return {7'b0000001, con, 2'b10};
        endcase
    endfunction

    function automatic vec_t make_vec(logic [31:0] w, bit con, int extra_off);
        vec_t        v;
        int unsigned c;
        c = int'(w[18:0]);
        v.ir        = w;
        v.con       = con;
        v.extra_off = extra_off;
        v.c2        = 2'((w >> 19) & 3);
        v.ra        = 4'((w >> 23) & 15);
        v.c_sext    = (c >= 32'h40000) ? (c - 32'h80000) : c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(int i);
        return (i == 0) ? 32'(cnt_a) : (i == 1) ? 32'(cnt_b) : 32'(cnt_c);
    endfunction

    task automatic check_counts(input string name);
        for (int i = 0; i < 3; i++) check($sformatf("%s_cnt%0d", name, i), cnt_of(i), cnt_m[i]);
    endtask

    task automatic check_idle(input string name);
        for (int i = 0; i < 3; i++) check($sformatf("%s_strb%0d", name, i), 32'(obs[i]), 32'd0);
    endtask

    task automatic run_txn(input vec_t v, input bit noise);
        @(posedge clock); #1;
        start = 1'b1;
        ir    = v.ir;
        con_d = noise ? 1'($urandom) : v.con;
        @(negedge clock);
        check_idle("pre_start");
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock); #1;
            start = (k == v.extra_off);
            ir    = noise ? {5'b10010, 27'($urandom)} : v.ir;
            con_d = (k == 1 || !noise) ? v.con : 1'($urandom);
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("step%0d_dut%0d", k, i), 32'(obs[i]), 32'(exp_vec(k, skip_of(i), v.con)));
                if (k <= 2) begin
                    check($sformatf("c2_k%0d_dut%0d", k, i), 32'(c2_v[i]), 32'(v.c2));
                    check($sformatf("ra_k%0d_dut%0d", k, i), 32'(ra_v[i]), 32'(v.ra));
                    check($sformatf("csext_k%0d_dut%0d", k, i), csext_v[i], v.c_sext);
                end
            end
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) cnt_m[i] = (cnt_m[i] + 32'(v.con)) % ((i == 2) ? 16 : 65536);
        check_counts("txn");
    endtask

    vec_t table_v [6];

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        ir      = '0;
        con_d   = 1'b0;
        for (int i = 0; i < 3; i++) cnt_m[i] = 0;

        table_v[0] = '{32'h9080_0005, 1'b1, 0, 2'd0, 4'd1, 32'h0000_0005};
        table_v[1] = '{32'h9080_0005, 1'b0, 0, 2'd0, 4'd1, 32'h0000_0005};
        table_v[2] = '{32'h9087_FFFF, 1'b0, 0, 2'd0, 4'd1, 32'hFFFF_FFFF};
        table_v[3] = '{32'h979C_0000, 1'b1, 0, 2'd3, 4'd15, 32'hFFFC_0000};
        table_v[4] = '{32'h9313_FFFF, 1'b1, 2, 2'd2, 4'd6, 32'h0003_FFFF};
        table_v[5] = '{32'h9080_0005, 1'b0, 2, 2'd0, 4'd1, 32'h0000_0005};

        #12;
        check_idle("reset");
        check_counts("reset");
        check("reset_csext", csext_v[0], 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int t = 0; t < 6; t++) run_txn(table_v[t], 1'b0);

        // Reset asserted while the taken branch is in its ADD step.
        @(posedge clock); #1;
        start = 1'b1; ir = 32'h9080_0005; con_d = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("mid_add_dut0", 32'(obs[0]), 32'(exp_vec(3, 1'b1, 1'b1)));
        #2 reset_n = 1'b0;
        #1;
        check_idle("mid_reset");
        for (int i = 0; i < 3; i++) cnt_m[i] = 0;
        check_counts("mid_reset");
        check("mid_reset_ra", 32'(ra_v[0]), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        check_idle("post_reset");
        @(negedge clock);
        check_idle("post_reset2");

        // Non-branch opcode must be ignored.
        @(posedge clock); #1;
        start = 1'b1; ir = 32'h0080_0005; con_d = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        check_idle("illegal_op");
        @(negedge clock);
        check_idle("illegal_op2");
        check_counts("illegal_op");

        // Sixteen taken branches wrap the 4-bit counter back to its start value.
        for (int n = 0; n < 16; n++) run_txn(make_vec({5'b10010, 27'($urandom)}, 1'b1, 0), 1'b1);
        check("wrap_cnt_c", 32'(cnt_c), 32'd0);

        for (int n = 0; n < 40; n++) begin
            bit con;
            con = 1'($urandom);
            run_txn(make_vec({5'b10010, 27'($urandom)}, con,
                             int'($urandom_range(0, con ? 5 : 2))), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Control-step sequencer for conditional-branch instructions. It sits directly downstream of the condition flip-flop logic and consumes its 1-bit result.
- It supplies the C2 condition code to that logic, latches the CON flag, and drives the bus/register strobes that compute PC + sign-extended C.
- It loads PC only when CON=1 and keeps a taken-branch counter for debug.

Parameters:
- BR_OPCODE, 5'b10010, opcode value in ir[31:27] that identifies a branch instruction.
- SKIP_NOT_TAKEN, 1, when 1 a not-taken branch jumps straight from S_CON to S_DONE; when 0 it walks every step with pc_in held low.
- CNT_W, 16, width of taken_count.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; ir valid in the same cycle
ir  in  32  instruction word: op[31:27] Ra[26:23] C2[20:19] C[18:0]
con_d  in  1  bit 0 of the condition flip-flop output
c2  out  2  condition code to the condition logic = ir_q[20:19]
ra_sel  out  4  register select for the Gra decode = ir_q[26:23]
gra_rout  out  1  drive R[ra_sel] onto the bus
pc_out  out  1  drive PC onto the bus
y_in  out  1  load Y
c_out  out  1  drive c_sext onto the bus
add_op  out  1  ALU operation = ADD
z_in  out  1  load Z
zlo_out  out  1  drive Zlow onto the bus
pc_in  out  1  load PC from the bus
c_sext  out  32  {{13{ir_q[18]}}, ir_q[18:0]}
con_q  out  1  latched CON flag
busy  out  1  high in every state except S_IDLE
done  out  1  one-cycle completion pulse
taken_count  out  CNT_W  number of taken branches, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, reset_n=0): state=S_IDLE, ir_q=0, con_q=0, taken_count=0. All strobes, busy and done are 0. c2, ra_sel and c_sext derive from ir_q, so they reset to 0. Reset wins in any state, including mid-sequence.
- States: S_IDLE, S_CON, S_PCY, S_ADD, S_PCLD, S_DONE. Encodings are a localparam enum.
- S_IDLE: if start=1 and ir[31:27]==BR_OPCODE, capture ir_q<=ir and go to S_CON. A start with any other opcode is ignored: no state change, no output activity.
- S_CON: gra_rout=1. con_q<=con_d at the clock edge. The condition logic is combinational, so con_d is valid in this same cycle. Next state is S_DONE if SKIP_NOT_TAKEN=1 and con_d=0; otherwise S_PCY. This decision uses con_d, not con_q.
- S_PCY: pc_out=1, y_in=1. Next state S_ADD.
- S_ADD: c_out=1, add_op=1, z_in=1. Next state S_PCLD.
- S_PCLD: zlo_out=1, pc_in=con_q. If con_q=1, taken_count increments, with wrap 0xFFFF->0 at the default width. Next state S_DONE.
- S_DONE: done=1. Next state S_IDLE.
- start while busy=1 is ignored; it is not queued. The next instruction can be accepted in the S_IDLE cycle after done.
- Latency from the start cycle N:
  - Taken: S_CON at N+1, pc_in at N+4, done at N+5, idle at N+6.
  - Not taken with skip: done at N+2.
  - Not taken without skip: done at N+5, pc_in never asserted.
- All strobe outputs are decoded combinationally from state only (Moore), except pc_in, which also uses con_q. No strobe may glitch between states.
- ir_q is held constant from S_CON through S_DONE.

Decomposition:
- Shared package branch_pkg: state enum, field position constants (OP_MSB/LSB, RA, C2, C field), default BR_OPCODE. The main control unit reuses these.
- One natural sub-module: branch_field_decode, purely combinational. It maps ir_q to c2, ra_sel and c_sext. The FSM, con_q register and counter stay in branch_sequencer.

Test Plan:
- Reset mid-sequence: start with ir=0x9080_0005, assert reset_n=0 during S_ADD -> all strobes, busy and done are 0 immediately; taken_count=0; after release, state is S_IDLE.
- Taken branch: ir=0x9080_0005 (op 18, Ra=1, C2=0, C=5), con_d=1 in S_CON -> c2=0, ra_sel=1, c_sext=0x0000_0005; pc_in=1 exactly at N+4; done at N+5; taken_count=1.
- Not taken with SKIP_NOT_TAKEN=1: same ir, con_d=0 -> done at N+2; pc_out, z_in and pc_in never asserted; taken_count unchanged.
- Negative offset, SKIP_NOT_TAKEN=0, not taken: C=0x7FFFF, con_d=0 -> c_sext=0xFFFF_FFFF, all steps walked, pc_in=0 throughout, done at N+5.
- Illegal and overlapping starts: start with op=5'b00000 -> busy stays 0. Start pulsed again at N+2 during a valid branch -> ignored, exactly one done pulse.
- Counter wrap: CNT_W=4, run 16 taken branches -> taken_count returns to 0.
